// File: rtl/mem_access_stage.sv
// MEM pipeline stage: performs the data-memory access over a req/ack handshake,
// stalls upstream while it is outstanding, and registers results into MEM/WB.
// Optional `MEM_TIMEOUT_EN adds a WAIT-state watchdog with a sticky mem_err flag.
module mem_access_stage #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned REG_AW         = 5,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Regfile_weM,
  input  logic              DataMem_weM,
  input  logic              MemToRegM,
  input  logic [REG_AW-1:0] writeRegAddrM,
  input  logic [DATA_W-1:0] aluOutM,
  input  logic [DATA_W-1:0] writeDataM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stallM,
  output logic              Regfile_weW,
  output logic [REG_AW-1:0] writeRegAddrW,
  output logic [DATA_W-1:0] resultW,
  output logic              mem_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0]        state;
  logic [DATA_W-1:0] rdata_hold;
  logic              memop;
  logic              is_load;
  logic              timeout;

  // A store wins when both memory flags are set.
  assign memop   = DataMem_weM | MemToRegM;
  assign is_load = MemToRegM & ~DataMem_weM;

  assign stallM = (state == WAIT) || ((state == IDLE) && memop);

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W =
      ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] wait_cnt;
  logic             err;

  assign timeout = (state == WAIT) && !dmem_ack &&
                   (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign mem_err = err;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if ((state == IDLE) && memop) begin
        wait_cnt <= '0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (timeout) begin
        err <= 1'b1;
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign mem_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      rdata_hold    <= '0;
      Regfile_weW   <= 1'b0;
      writeRegAddrW <= '0;
      resultW       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (memop) begin
            dmem_req    <= 1'b1;
            dmem_we     <= DataMem_weM;
            dmem_addr   <= {aluOutM[DATA_W-1:2], 2'b00};
            dmem_wdata  <= writeDataM;
            Regfile_weW <= 1'b0;
            state       <= WAIT;
          end else begin
            Regfile_weW   <= Regfile_weM;
            writeRegAddrW <= writeRegAddrM;
            resultW       <= aluOutM;
          end
        end
        WAIT: begin
          Regfile_weW <= 1'b0;
          if (dmem_ack) begin
            dmem_req   <= 1'b0;
            rdata_hold <= dmem_rdata;
            state      <= DONE;
          end else if (timeout) begin
            // Abandoned access: pipeline resumes with a zero load result.
            dmem_req   <= 1'b0;
            rdata_hold <= '0;
            state      <= DONE;
          end
        end
        DONE: begin
          Regfile_weW   <= Regfile_weM;
          writeRegAddrW <= writeRegAddrM;
          resultW       <= is_load ? rdata_hold : aluOutM;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Consumer end of the EX/MEM pipeline register: takes the M-stage bundle, performs the data-memory access over a req/ack handshake, and registers results into the MEM/WB stage.
- Freezes the upstream pipeline (stall) while a load or store is outstanding.
- Inserts a bubble into WB during a stall; non-memory instructions pass to WB with one-cycle latency.

Parameters:
- DATA_W, 32, data/address word width
- REG_AW, 5, register-file address width
- TIMEOUT_CYCLES, 255, WAIT-state watchdog limit (used only with MEM_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- Regfile_weM  in  1  M-stage register-file write enable
- DataMem_weM  in  1  M-stage store
- MemToRegM  in  1  M-stage load (WB result comes from memory)
- writeRegAddrM  in  REG_AW  M-stage destination register
- aluOutM  in  DATA_W  effective address or ALU result
- writeDataM  in  DATA_W  store data
- dmem_req  out  1  memory request, held until ack
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  DATA_W  word-aligned address
- dmem_wdata  out  DATA_W  write data
- dmem_ack  in  1  memory completion, single-cycle pulse
- dmem_rdata  in  DATA_W  read data, valid when dmem_ack = 1
- stallM  out  1  freeze IF/ID/EX/M registers
- Regfile_weW  out  1  WB write enable
- writeRegAddrW  out  REG_AW  WB destination register
- resultW  out  DATA_W  WB write data
- mem_err  out  1  sticky timeout flag (MEM_TIMEOUT_EN only; otherwise tied 0)

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - On reset, all registered outputs are 0 and state = IDLE.
  - Reset mid-WAIT drops dmem_req the next cycle; a later dmem_ack is ignored.
- memop = DataMem_weM | MemToRegM. If both are set, treat as a store; MemToRegM is ignored.
- States: IDLE, WAIT, DONE.
- IDLE:
  - memop = 0: no request, stallM = 0. On the clock edge, the WB registers take Regfile_weM, writeRegAddrM and aluOutM.
  - memop = 1: stallM = 1 combinationally. On the edge:
    - dmem_req <= 1, dmem_we <= DataMem_weM;
    - dmem_addr <= {aluOutM[DATA_W-1:2], 2'b00}, dmem_wdata <= writeDataM;
    - Regfile_weW <= 0 (bubble); state -> WAIT.
- WAIT:
  - stallM = 1; request signals are held stable; Regfile_weW <= 0 each cycle.
  - On dmem_ack: dmem_req <= 0, read data is captured into an internal holding register, state -> DONE.
- DONE:
  - stallM = 0. On the edge, the WB registers take Regfile_weM and writeRegAddrM.
  - resultW <= captured data if MemToRegM, otherwise aluOutM.
  - For a store, Regfile_weW <= Regfile_weM (normally 0).
  - state -> IDLE, so the next M instruction is evaluated fresh.
- dmem_ack while in IDLE or DONE is ignored.
- Minimum memory-op cost: 2 stall cycles (ack arrives in the first WAIT cycle) plus 1 DONE cycle.
- The M-stage inputs are stable throughout a stall; the block does not re-latch them.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - An 8+ bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When the count reaches TIMEOUT_CYCLES without ack: dmem_req <= 0, mem_err <= 1 (sticky until rst), resultW data = 0, state -> DONE. The pipeline resumes.
- MEM_TIMEOUT_EN undefined: no counter; WAIT persists indefinitely; mem_err is constant 0.

Test Plan:
- Reset: hold rst 2 cycles → all outputs 0, stallM = 0, dmem_req = 0.
- ALU op (Regfile_weM = 1, writeRegAddrM = 5'd3, aluOutM = 0x0000_0010) → next cycle Regfile_weW = 1, writeRegAddrW = 3, resultW = 0x10, stallM never asserted.
- Store (DataMem_weM = 1, aluOutM = 0x0000_0103, writeDataM = 0xDEAD_BEEF), ack 3 cycles after req → dmem_addr = 0x100, dmem_we = 1, dmem_wdata = 0xDEADBEEF. stallM high through the ack cycle, then low in DONE; Regfile_weW = 0 throughout.
- Load (MemToRegM = 1, Regfile_weM = 1, writeRegAddrM = 5'd8, aluOutM = 0x20), ack in the first WAIT cycle with rdata = 0x1234_5678 → after DONE, Regfile_weW = 1, writeRegAddrW = 8, resultW = 0x12345678.
- Stray ack pulsed in IDLE, then rst asserted mid-WAIT with a late ack → no state change from the stray ack; after reset dmem_req = 0, state IDLE, no WB write.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES = 4, load with no ack → req drops after 4 WAIT cycles, mem_err = 1 and stays 1, resultW = 0, stallM deasserts.
